// File: rtl/div32_16_seq.sv
// Iterative 32/16 restoring divider (DIV/IDIV word path), one shift/subtract step per clock.
// Optional macro SIGNED_DIV_EN adds the sgn port and two's-complement (IDIV) handling.
module div32_16_seq #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [15:0] b,
`ifdef SIGNED_DIV_EN
    input  logic        sgn,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic [15:0] r,
    output logic        de
);

    typedef enum logic [2:0] {IDLE, RUN, FIX, FIN, ERR} state_t;

    state_t      state_q, state_d;
    logic [16:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [15:0] dvs_q, dvs_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic [15:0] q_q, q_d, r_q, r_d;
    logic        de_q, de_d;

    logic [31:0] a_mag;
    logic [15:0] b_mag;
    logic [17:0] trial;

`ifdef SIGNED_DIV_EN
    logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;

    always_comb begin
        a_mag = (sgn && a[31]) ? -a : a;
        b_mag = (sgn && b[15]) ? -b : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // One extra bit above the 17-bit difference serves as the borrow (negative trial).
    assign trial = {rem_q, dvd_q[31]} - {2'b00, dvs_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        de_d    = de_q;
`ifdef SIGNED_DIV_EN
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b_mag == 16'h0 || a_mag[31:16] >= b_mag) begin
                        state_d = ERR;
                    end else begin
                        rem_d   = {1'b0, a_mag[31:16]};
                        dvd_d   = {a_mag[15:0], 16'h0};
                        dvs_d   = b_mag;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
`ifdef SIGNED_DIV_EN
                        sgn_d   = sgn;
                        qneg_d  = sgn & (a[31] ^ b[15]);
                        rneg_d  = sgn & a[31];
`endif
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!trial[17]) begin
                    rem_d = trial[16:0];
                    dvd_d = {dvd_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[15:0], dvd_q[31]};
                    dvd_d = {dvd_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITER - 1)) state_d = FIX;
            end
            FIX: begin
`ifdef SIGNED_DIV_EN
                if (sgn_q) begin
                    ovf_d = qneg_q ? (dvd_q[15:0] > 16'h8000) : (dvd_q[15:0] > 16'h7FFF);
                    if (qneg_q) dvd_d[15:0] = -dvd_q[15:0];
                    if (rneg_q) rem_d = {1'b0, -rem_q[15:0]};
                end
`endif
                state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                q_d     = ovf_q ? 16'h0 : dvd_q[15:0];
                r_d     = ovf_q ? 16'h0 : rem_q[15:0];
                de_d    = ovf_q;
                state_d = IDLE;
            end
            ERR: begin
                done_d  = 1'b1;
                q_d     = 16'h0;
                r_d     = 16'h0;
                de_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            de_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            de_q    <= de_d;
`ifdef SIGNED_DIV_EN
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign de   = de_q;

endmodule

// File: tb/tb_div32_16_seq.sv
// Self-checking bench for div32_16_seq: directed table, busy/reset sequences, random vs. arithmetic model.
module tb_div32_16_seq;

    logic        clk = 1'b0;
    logic        rst, start, sgn;
    logic [31:0] a;
    logic [15:0] b;
    logic        busy, done, de;
    logic [15:0] q, r;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    div32_16_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
`ifdef SIGNED_DIV_EN
        .sgn  (sgn),
`endif
        .busy (busy),
        .done (done),
        .q    (q),
        .r    (r),
        .de   (de)
    );

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] eq;
        logic [15:0] er;
        logic        ede;
        int          elat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the early and late error rules.
    task automatic ref_div(input logic [31:0] ai, input logic [15:0] bi, input logic si,
                           output logic [15:0] eq, output logic [15:0] er,
                           output logic ede, output int elat);
        longint sa, sb, ma, mb, qv, rv;
        eq = 16'h0; er = 16'h0; ede = 1'b1; elat = 1;
        if (si) begin
            sa = longint'($signed(ai));
            sb = longint'($signed(bi));
        end else begin
            sa = longint'(ai);
            sb = longint'(bi);
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (mb == 0 || (ma >> 16) >= mb) return;
        elat = 18;
        qv = sa / sb;
        rv = sa % sb;
        if (si && (qv > 32767 || qv < -32768)) return;
        ede = 1'b0;
        eq = qv[15:0];
        er = rv[15:0];
    endtask

    task automatic run(input logic [31:0] ai, input logic [15:0] bi, input logic si,
                       output logic [15:0] qo, output logic [15:0] ro,
                       output logic deo, output int lat);
        @(negedge clk);
        a = ai; b = bi; sgn = si; start = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        qo = q; ro = r; deo = de;
        chk("busy_in_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [15:0] qo, ro;
        logic        deo;
        int          lat;
        run(v.a, v.b, v.s, qo, ro, deo, lat);
        chk({tag, "_lat"}, lat, v.elat);
        chk({tag, "_q"}, qo, v.eq);
        chk({tag, "_r"}, ro, v.er);
        chk({tag, "_de"}, deo, v.ede);
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [15:0] qs, rs;
        logic        des;
        int          dcnt;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_de", de, 0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{32'h0000_0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 18});
        tbl.push_back('{32'h0001_FFFF, 16'h0002, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 18});
        tbl.push_back('{32'h0000_1234, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1});
        tbl.push_back('{32'h0002_0000, 16'h0002, 1'b0, 16'h0000, 16'h0000, 1'b1, 1});
        tbl.push_back('{32'hFFFE_FFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFE, 1'b0, 18});
        tbl.push_back('{32'hFFFF_0000, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1, 1});
        tbl.push_back('{32'h0000_FFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 18});
        tbl.push_back('{32'h0000_0000, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 18});
`ifdef SIGNED_DIV_EN
        tbl.push_back('{32'hFFFF_FFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 18});
        tbl.push_back('{32'h0000_8000, 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b1, 18});
        tbl.push_back('{32'hFFFF_8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b0, 18});
        tbl.push_back('{32'h0000_0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 18});
`endif
        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Starts while busy must be ignored; exactly one done with the original result.
        @(negedge clk);
        a = 32'h0000_0064; b = 16'h0007; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        dcnt = 0; qs = '0; rs = '0; des = 1'b1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            if (cyc == 3 || cyc == 9) begin
                a = 32'h0000_1234; b = 16'h0000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dcnt++;
                qs = q; rs = r; des = de;
            end
        end
        chk("busy_start_dones", dcnt, 1);
        chk("busy_start_q", qs, 16'h000E);
        chk("busy_start_r", rs, 16'h0002);
        chk("busy_start_de", des, 0);

        // Reset mid-run aborts with no done and clears the outputs.
        @(negedge clk);
        a = 32'h0000_0064; b = 16'h0007; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_q", q, 0);
        chk("midrst_r", r, 0);
        chk("midrst_de", de, 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);

        for (int k = 0; k < 60; k++) begin
            logic [15:0] bb;
            logic [31:0] aa;
            bb = 16'($urandom);
            if (k % 10 == 0) bb = 16'h0;
            aa = $urandom;
            if (k % 4 != 0 && bb != 16'h0) aa[31:16] = 16'($urandom_range(0, 32'(bb) - 1));
            v.a = aa; v.b = bb;
`ifdef SIGNED_DIV_EN
            v.s = 1'($urandom);
`else
            v.s = 1'b0;
`endif
            ref_div(v.a, v.b, v.s, v.eq, v.er, v.ede, v.elat);
            apply(v, $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
